// File: rtl/sccomp_mem_arbiter.sv
// rtl/sccomp_mem_arbiter.sv - unified fetch/data word memory: arbitration, wait states, AdEL/AdES decode (option macro: ARB_ROUND_ROBIN_EN)
module sccomp_mem_arbiter #(
    parameter int          DATA_W      = 32,
    parameter int          IM_DEPTH    = 2048,
    parameter int          DM_DEPTH    = 2048,
    parameter logic [31:0] IM_BASE     = 32'h00400000,
    parameter logic [31:0] DM_BASE     = 32'h10010000,
    parameter int          WAIT_STATES = 2
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,
    output logic [4:0]        exc_cause,
    output logic              busy
);

    localparam int MEM_DEPTH = IM_DEPTH + DM_DEPTH;
    localparam int AW        = $clog2(MEM_DEPTH);
    localparam int CNT_W     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // Instruction words live at 0..IM_DEPTH-1, data words directly above them.
    logic [DATA_W-1:0] mem_array [MEM_DEPTH];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              port_dm_q, port_dm_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              if_err_q, if_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              dm_ack_q, dm_ack_d;
    logic              dm_err_q, dm_err_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic [4:0]        exc_cause_q, exc_cause_d;
    logic              busy_q, busy_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_dm_q, last_dm_d;
`endif

    logic [31:0]       if_off, if_word, dm_off, dm_word;
    logic              if_bad, dm_bad;
    logic [AW-1:0]     if_idx, dm_idx;
    logic              grant_dm, grant_if;
    logic              mem_we;

    // Address decode: offsets wrap, so addresses below a base land far out of range.
    always_comb begin
        if_off  = if_addr - IM_BASE;
        if_word = if_off >> 2;
        if_bad  = (if_addr[1:0] != 2'b00) || (if_word >= 32'(IM_DEPTH));
        if_idx  = AW'(if_word);
        dm_off  = dm_addr - DM_BASE;
        dm_word = dm_off >> 2;
        dm_bad  = (dm_addr[1:0] != 2'b00) || (dm_word >= 32'(DM_DEPTH));
        dm_idx  = AW'(dm_word + 32'(IM_DEPTH));
    end

    // Port selection when both request in IDLE.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (dm_req && if_req) begin
            grant_dm = !last_dm_q;
        end else begin
            grant_dm = dm_req;
        end
`else
        grant_dm = dm_req;
`endif
        grant_if = if_req && !grant_dm;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        port_dm_d   = port_dm_q;
        we_d        = we_q;
        err_d       = err_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = '0;
        dm_ack_d    = 1'b0;
        dm_err_d    = 1'b0;
        dm_rdata_d  = '0;
        exc_cause_d = exc_cause_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_dm_d   = last_dm_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_dm || grant_if) begin
                    port_dm_d = grant_dm;
                    we_d      = grant_dm && dm_we;
                    wdata_d   = dm_wdata;
                    err_d     = grant_dm ? dm_bad : if_bad;
                    idx_d     = grant_dm ? dm_idx : if_idx;
                    cnt_d     = '0;
                    if ((grant_dm ? dm_bad : if_bad) || (WAIT_STATES == 0)) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_dm_d = grant_dm;
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (port_dm_q) begin
                    dm_ack_d   = 1'b1;
                    dm_err_d   = err_q;
                    dm_rdata_d = (err_q || we_q) ? '0 : mem_array[idx_q];
                end else begin
                    if_ack_d   = 1'b1;
                    if_err_d   = err_q;
                    if_rdata_d = err_q ? '0 : mem_array[idx_q];
                end
                if (err_q) begin
                    exc_cause_d = (port_dm_q && we_q) ? EXC_ADES : EXC_ADEL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // busy mirrors the state that will be held after this edge.
    always_comb begin
        busy_d = (state_d != S_IDLE);
    end

    // Controller state and output registers; reset aborts any in-flight access.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            port_dm_q   <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_ack_q    <= 1'b0;
            dm_err_q    <= 1'b0;
            dm_rdata_q  <= '0;
            exc_cause_q <= 5'd0;
            busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dm_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_dm_q   <= port_dm_d;
            we_q        <= we_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_ack_q    <= dm_ack_d;
            dm_err_q    <= dm_err_d;
            dm_rdata_q  <= dm_rdata_d;
            exc_cause_q <= exc_cause_d;
            busy_q      <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_dm_q   <= last_dm_d;
`endif
        end
    end

    // Stores commit on the edge that raises dm_ack; only a valid data store writes.
    assign mem_we = (state_q == S_RESP) && port_dm_q && we_q && !err_q;

    // Word array keeps its contents through reset.
    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem_array[idx_q] <= wdata_q;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign dm_err    = dm_err_q;
    assign dm_rdata  = dm_rdata_q;
    assign exc_cause = exc_cause_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sccomp_mem_arbiter.sv
// tb/tb_sccomp_mem_arbiter.sv - randomized self-checking bench for sccomp_mem_arbiter
module tb_sccomp_mem_arbiter;

    localparam int          WS   = 2;
    localparam int          IM_D = 2048;
    localparam int          DM_D = 2048;
    localparam logic [31:0] IM_B = 32'h00400000;
    localparam logic [31:0] DM_B = 32'h10010000;
    localparam int          Z_D  = 16;

    logic        clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        if_ack, if_err, dm_ack, dm_err, busy;
    logic [31:0] if_rdata, dm_rdata;
    logic [4:0]  exc_cause;

    logic        z_if_req, z_dm_req, z_dm_we;
    logic [31:0] z_if_addr, z_dm_addr, z_dm_wdata;
    logic        z_if_ack, z_if_err, z_dm_ack, z_dm_err, z_busy;
    logic [31:0] z_if_rdata, z_dm_rdata;
    logic [4:0]  z_exc_cause;

    sccomp_mem_arbiter #(.DATA_W(32), .IM_DEPTH(IM_D), .DM_DEPTH(DM_D), .IM_BASE(IM_B),
                         .DM_BASE(DM_B), .WAIT_STATES(WS)) dut (
        .clk_in(clk_in), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .exc_cause(exc_cause), .busy(busy));

    sccomp_mem_arbiter #(.DATA_W(32), .IM_DEPTH(Z_D), .DM_DEPTH(Z_D), .IM_BASE(IM_B),
                         .DM_BASE(DM_B), .WAIT_STATES(0)) dut0 (
        .clk_in(clk_in), .reset(reset),
        .if_req(z_if_req), .if_addr(z_if_addr), .if_ack(z_if_ack), .if_rdata(z_if_rdata), .if_err(z_if_err),
        .dm_req(z_dm_req), .dm_we(z_dm_we), .dm_addr(z_dm_addr), .dm_wdata(z_dm_wdata),
        .dm_ack(z_dm_ack), .dm_rdata(z_dm_rdata), .dm_err(z_dm_err),
        .exc_cause(z_exc_cause), .busy(z_busy));

    int          checks = 0;
    int          errors = 0;
    logic [31:0] im_model [IM_D];
    logic [31:0] dm_model [DM_D];
    logic [4:0]  exp_exc;
    bit          rr_last_dm;

    // Reference decode: word offset from base, alignment and region bounds.
    function automatic bit addr_bad(input logic [31:0] addr, input logic [31:0] base,
                                    input int depth, output int word);
        logic [31:0] off;
        off  = addr - base;
        word = int'(off >> 2);
        return (addr[1:0] != 2'b00) || ((off >> 2) >= 32'(depth));
    endfunction

    function automatic logic [31:0] gen_addr(input bit is_dm);
        logic [31:0] base, other;
        int unsigned hi, sel;
        base  = is_dm ? DM_B : IM_B;
        other = is_dm ? IM_B : DM_B;
        hi    = is_dm ? 32'd15 : 32'(IM_D - 1);
        sel   = $urandom_range(0, 7);
        case (sel)
            0, 1, 2: return base + 32'(4 * $urandom_range(0, hi));
            3:       return base + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            4:       return base + 32'(4 * (is_dm ? DM_D : IM_D)) + 32'(4 * $urandom_range(0, 3));
            5:       return base - 32'(4 * $urandom_range(1, 4));
            6:       return other + 32'(4 * $urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // One complete access on the main instance, checked against the model.
    task automatic do_access(input bit is_dm, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input string name);
        bit          e, got, er, oth;
        int          w, exp_lat, lat;
        logic [31:0] exp_rd, rd;
        logic [4:0]  ex;
        e = is_dm ? addr_bad(addr, DM_B, DM_D, w) : addr_bad(addr, IM_B, IM_D, w);
        exp_lat = e ? 1 : WS + 1;
        exp_rd  = 32'h0;
        if (!e && !we) exp_rd = is_dm ? dm_model[w] : im_model[w];
        if (e) exp_exc = (is_dm && we) ? 5'd5 : 5'd4;
        rr_last_dm = is_dm;
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        @(posedge clk_in); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_grant got %b want 1", name, busy);
        end
        dm_addr = $urandom; dm_wdata = $urandom; dm_we = ~dm_we; if_addr = $urandom;
        got = 1'b0; lat = 0; rd = 32'h0; er = 1'b0; ex = 5'd0; oth = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk_in); #1;
            lat++;
            if (is_dm ? dm_ack : if_ack) begin
                got = 1'b1;
                rd  = is_dm ? dm_rdata : if_rdata;
                er  = is_dm ? dm_err : if_err;
                ex  = exc_cause;
                oth = is_dm ? if_ack : dm_ack;
            end
        end
        dm_req = 1'b0; if_req = 1'b0; dm_we = 1'b0;
        checks++;
        if (!got) begin
            errors++; $display("FAIL %s ack_timeout got none want ack after %0d", name, exp_lat);
        end else begin
            checks++;
            if (lat != exp_lat) begin
                errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
            end
            checks++;
            if (er !== e) begin
                errors++; $display("FAIL %s err got %b want %b", name, er, e);
            end
            checks++;
            if (rd !== exp_rd) begin
                errors++; $display("FAIL %s rdata got %h want %h", name, rd, exp_rd);
            end
            checks++;
            if (ex !== exp_exc) begin
                errors++; $display("FAIL %s exc_cause got %0d want %0d", name, ex, exp_exc);
            end
            checks++;
            if (oth !== 1'b0) begin
                errors++; $display("FAIL %s other_port_ack got %b want 0", name, oth);
            end
        end
        @(posedge clk_in); #1;
        checks++;
        if ({dm_ack, if_ack, dm_rdata, if_rdata} !== 66'h0) begin
            errors++; $display("FAIL %s ack_pulse got ack %b%b rdata %h %h want zeros",
                               name, dm_ack, if_ack, dm_rdata, if_rdata);
        end
        if (!e && we && is_dm) dm_model[w] = wdata;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if ({if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err, exc_cause, busy} !== 74'h0) begin
            errors++; $display("FAIL reset_outputs got %h want 0",
                               {if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err, exc_cause, busy});
        end
        reset = 1'b1;
        @(posedge clk_in); #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = DM_B; dm_wdata = 32'hDEADBEEF;
        @(posedge clk_in); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_pre_busy got %b want 1", busy);
        end
        @(posedge clk_in); #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err, exc_cause, busy} !== 74'h0) begin
            errors++; $display("FAIL reset_midwait_outputs got %h want 0",
                               {if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err, exc_cause, busy});
        end
        dm_req = 1'b0; dm_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in); #1;
            checks++;
            if ((dm_ack !== 1'b0) || (busy !== 1'b0)) begin
                errors++; $display("FAIL reset_hold_%0d got ack %b busy %b want 0 0", i, dm_ack, busy);
            end
        end
        reset = 1'b1;
        exp_exc = 5'd0;
        rr_last_dm = 1'b0;
        @(posedge clk_in); #1;
        do_access(1'b1, 1'b0, DM_B, 32'h0, "reset_no_write");
    endtask

    task automatic test_fetch();
        do_access(1'b0, 1'b0, 32'h00400008, 32'h0, "fetch_word2");
        do_access(1'b0, 1'b0, IM_B + 32'(4 * (IM_D - 1)), 32'h0, "fetch_last");
    endtask

    task automatic test_store_load();
        do_access(1'b1, 1'b1, 32'h10010004, 32'h12345678, "store");
        do_access(1'b1, 1'b0, 32'h10010004, 32'h0, "load");
        do_access(1'b1, 1'b1, DM_B + 32'(4 * (DM_D - 1)), 32'hA5A55A5A, "store_last");
        do_access(1'b1, 1'b0, DM_B + 32'(4 * (DM_D - 1)), 32'h0, "load_last");
    endtask

    task automatic test_errors();
        do_access(1'b1, 1'b0, 32'h10010002, 32'h0, "load_misaligned");
        do_access(1'b1, 1'b1, 32'h10012000, 32'hFFFFFFFF, "store_oob");
        do_access(1'b1, 1'b0, 32'h10011FFC, 32'h0, "load_after_oob");
        do_access(1'b0, 1'b0, 32'h003FFFFC, 32'h0, "fetch_below_base");
        do_access(1'b0, 1'b0, DM_B, 32'h0, "fetch_data_region");
        do_access(1'b1, 1'b0, IM_B + 32'd8, 32'h0, "load_text_region");
    endtask

    task automatic test_contention();
        bit          first_dm, seen_dm, seen_if;
        int          cyc, t_dm, t_if, t_first, t_second;
        logic [31:0] got_dm, got_if, exp_dm, exp_if;
        do_access(1'b0, 1'b0, IM_B, 32'h0, "pre_contention_fetch");
        for (int r = 0; r < 3; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
            first_dm = !rr_last_dm;
`else
            first_dm = 1'b1;
`endif
            rr_last_dm = !first_dm;
            exp_dm = dm_model[1];
            exp_if = im_model[r + 5];
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = DM_B + 32'd4;
            if_req = 1'b1; if_addr = IM_B + 32'(4 * (r + 5));
            seen_dm = 1'b0; seen_if = 1'b0; cyc = 0; t_dm = 0; t_if = 0;
            got_dm = 32'h0; got_if = 32'h0;
            while (!(seen_dm && seen_if) && cyc < 40) begin
                @(posedge clk_in); #1;
                cyc++;
                if (dm_ack && !seen_dm) begin
                    seen_dm = 1'b1; t_dm = cyc; got_dm = dm_rdata; dm_req = 1'b0;
                end
                if (if_ack && !seen_if) begin
                    seen_if = 1'b1; t_if = cyc; got_if = if_rdata; if_req = 1'b0;
                end
            end
            dm_req = 1'b0; if_req = 1'b0;
            checks++;
            if (!(seen_dm && seen_if)) begin
                errors++; $display("FAIL contention_%0d ack_timeout got dm %b if %b want both", r, seen_dm, seen_if);
            end else begin
                t_first  = first_dm ? t_dm : t_if;
                t_second = first_dm ? t_if : t_dm;
                checks++;
                if (t_first != WS + 2) begin
                    errors++; $display("FAIL contention_%0d first_%s got cycle %0d want %0d",
                                       r, first_dm ? "dm" : "if", t_first, WS + 2);
                end
                checks++;
                if (t_second != 2 * WS + 4) begin
                    errors++; $display("FAIL contention_%0d second got cycle %0d want %0d", r, t_second, 2 * WS + 4);
                end
                checks++;
                if ((got_dm !== exp_dm) || (got_if !== exp_if)) begin
                    errors++; $display("FAIL contention_%0d rdata got %h %h want %h %h", r, got_dm, got_if, exp_dm, exp_if);
                end
            end
            @(posedge clk_in); #1;
        end
    endtask

    task automatic test_random();
        bit          is_dm, we;
        logic [31:0] a;
        for (int i = 0; i < 80; i++) begin
            is_dm = ($urandom_range(0, 1) == 1);
            we    = is_dm && ($urandom_range(0, 1) == 1);
            a     = gen_addr(is_dm);
            do_access(is_dm, we, a, $urandom, $sformatf("random_%0d", i));
        end
    endtask

    task automatic test_zero_wait();
        z_dm_req = 1'b1; z_dm_we = 1'b0; z_dm_addr = DM_B + 32'd12;
        @(posedge clk_in); #1;
        checks++;
        if ((z_busy !== 1'b1) || (z_dm_ack !== 1'b0)) begin
            errors++; $display("FAIL zws_grant got busy %b ack %b want 1 0", z_busy, z_dm_ack);
        end
        @(posedge clk_in); #1;
        checks++;
        if ((z_dm_ack !== 1'b1) || (z_dm_rdata !== 32'hCAFEF00D) || (z_dm_err !== 1'b0) || (z_busy !== 1'b0)) begin
            errors++; $display("FAIL zws_load got ack %b rdata %h err %b busy %b want 1 cafef00d 0 0",
                               z_dm_ack, z_dm_rdata, z_dm_err, z_busy);
        end
        z_dm_req = 1'b0;
        @(posedge clk_in); #1;
        z_if_req = 1'b1; z_if_addr = IM_B + 32'd6;
        @(posedge clk_in); #1;
        z_if_addr = IM_B + 32'd4;
        @(posedge clk_in); #1;
        checks++;
        if ((z_if_ack !== 1'b1) || (z_if_err !== 1'b1) || (z_if_rdata !== 32'h0) || (z_exc_cause !== 5'd4)) begin
            errors++; $display("FAIL zws_fetch_err got ack %b err %b rdata %h exc %0d want 1 1 0 4",
                               z_if_ack, z_if_err, z_if_rdata, z_exc_cause);
        end
        z_if_req = 1'b0;
        @(posedge clk_in); #1;
        z_if_req = 1'b1; z_if_addr = IM_B + 32'd4;
        @(posedge clk_in); #1;
        z_if_req = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if ((z_if_ack !== 1'b1) || (z_if_rdata !== 32'h8C080000) || (z_if_err !== 1'b0)) begin
            errors++; $display("FAIL zws_fetch got ack %b rdata %h err %b want 1 8c080000 0",
                               z_if_ack, z_if_rdata, z_if_err);
        end
        @(posedge clk_in); #1;
    endtask

    initial begin
        reset = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        z_if_req = 1'b0; z_if_addr = 32'h0; z_dm_req = 1'b0; z_dm_we = 1'b0; z_dm_addr = 32'h0; z_dm_wdata = 32'h0;
        exp_exc = 5'd0;
        rr_last_dm = 1'b0;
        for (int i = 0; i < IM_D; i++) begin
            im_model[i] = $urandom;
            dut.mem_array[i] = im_model[i];
        end
        for (int i = 0; i < DM_D; i++) begin
            dm_model[i] = 32'h0;
            dut.mem_array[IM_D + i] = 32'h0;
        end
        im_model[2] = 32'h2408000A;
        dut.mem_array[2] = 32'h2408000A;
        for (int i = 0; i < 2 * Z_D; i++) dut0.mem_array[i] = 32'h0;
        dut0.mem_array[Z_D + 3] = 32'hCAFEF00D;
        dut0.mem_array[1] = 32'h8C080000;

        test_reset();
        test_fetch();
        test_store_load();
        test_errors();
        test_contention();
        test_random();
        test_zero_wait();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
